lot_occupancy_counter: RTL and testbench

Multi-lane parking-lot occupancy counter. Each lane has two beam sensors (a outside, b inside); every sensor pair is synchronised, debounced and decoded by a direction FSM that emits one-cycle enter/exit pulses. A shared saturating counter tracks the cars in the lot against a configurable capacity. The block is a parametrised successor of the single-lane two-sensor counter top level and sits directly behind the sensor input pins.

---
 rtl/lot_occupancy_pkg.sv | 31 +++
 rtl/lot_occupancy_counter_lane_decoder.sv | 164 ++++++++++++++++
 rtl/lot_occupancy_counter.sv | 100 ++++++++++
 tb/tb_lot_occupancy_counter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lot_occupancy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lot_occupancy_pkg
// Brief    : Shared lane FSM state encoding and helpers for the lot counter.
// Revision : 1.0 - initial release
// ============================================================================
package lot_occupancy_pkg;

    localparam int c_max_lanes = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EN1  = 3'd1,
        EN2  = 3'd2,
        EN3  = 3'd3,
        EX1  = 3'd4,
        EX2  = 3'd5,
        EX3  = 3'd6
    } lane_state_e;

    function automatic logic [3:0] popcount8(input logic [c_max_lanes-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < c_max_lanes; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lot_occupancy_counter_lane_decoder.sv
`default_nettype none
// ============================================================================
// Module   : lot_lane_decoder
// Brief    : One lane: synchronise and debounce both beams, decode direction.
// Options  : LOT_DEBOUNCE_EN - debouncers present (otherwise sync only)
// Revision : 1.0 - initial release
// ============================================================================
module lot_lane_decoder
    import lot_occupancy_pkg::*;
#(
    parameter int DB_CYCLES = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic db_a,
    output logic db_b,
    output logic enter,
    output logic exit
);

    logic [1:0] w_raw;
    logic [1:0] w_db;
    logic [1:0] w_ab;

    assign w_raw = {b, a};

    for (genvar i = 0; i < 2; i++) begin : g_bit
        logic r_s1;
        logic r_s2;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_s1 <= 1'b0;
                r_s2 <= 1'b0;
            end else begin
                r_s1 <= w_raw[i];
                r_s2 <= r_s1;
            end
        end

`ifdef LOT_DEBOUNCE_EN
        localparam int c_cnt_w = $clog2(DB_CYCLES + 1);
        localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DB_CYCLES - 1);

        logic [c_cnt_w-1:0] r_cnt;
        logic               r_db;

        // Any sample agreeing with the accepted level restarts the run.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt <= '0;
                r_db  <= 1'b0;
            end else if (r_s2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_last) begin
                r_cnt <= '0;
                r_db  <= r_s2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_db[i] = r_db;
`else
        assign w_db[i] = r_s2;
`endif
    end

    assign db_a = w_db[0];
    assign db_b = w_db[1];
    assign w_ab = {w_db[0], w_db[1]};

    lane_state_e r_state;
    lane_state_e w_state_nxt;
    logic        r_enter;
    logic        r_exit;
    logic        w_enter_nxt;
    logic        w_exit_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_enter <= 1'b0;
            r_exit  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_enter <= w_enter_nxt;
            r_exit  <= w_exit_nxt;
        end
    end

    // w_ab is {a, b}: entries see a first, exits see b first.
    always_comb begin
        w_state_nxt = r_state;
        w_enter_nxt = 1'b0;
        w_exit_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ab == 2'b10)      w_state_nxt = EN1;
                else if (w_ab == 2'b01) w_state_nxt = EX1;
            end
            EN1: begin
                case (w_ab)
                    2'b11:   w_state_nxt = EN2;
                    2'b10:   w_state_nxt = EN1;
                    default: w_state_nxt = IDLE;
                endcase
            end
            EN2: begin
                case (w_ab)
                    2'b01:   w_state_nxt = EN3;
                    2'b10:   w_state_nxt = EN1;
                    2'b11:   w_state_nxt = EN2;
                    default: w_state_nxt = IDLE;
                endcase
            end
            EN3: begin
                case (w_ab)
                    2'b00: begin
                        w_state_nxt = IDLE;
                        w_enter_nxt = 1'b1;
                    end
                    2'b11:   w_state_nxt = EN2;
                    2'b01:   w_state_nxt = EN3;
                    default: w_state_nxt = IDLE;
                endcase
            end
            EX1: begin
                case (w_ab)
                    2'b11:   w_state_nxt = EX2;
                    2'b01:   w_state_nxt = EX1;
                    default: w_state_nxt = IDLE;
                endcase
            end
            EX2: begin
                case (w_ab)
                    2'b10:   w_state_nxt = EX3;
                    2'b01:   w_state_nxt = EX1;
                    2'b11:   w_state_nxt = EX2;
                    default: w_state_nxt = IDLE;
                endcase
            end
            EX3: begin
                case (w_ab)
                    2'b00: begin
                        w_state_nxt = IDLE;
                        w_exit_nxt  = 1'b1;
                    end
                    2'b11:   w_state_nxt = EX2;
                    2'b10:   w_state_nxt = EX3;
                    default: w_state_nxt = IDLE;
                endcase
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign enter = r_enter;
    assign exit  = r_exit;

endmodule
`default_nettype wire

// File: rtl/lot_occupancy_counter.sv
`default_nettype none
// ============================================================================
// Module   : lot_occupancy_counter
// Brief    : Multi-lane parking-lot occupancy counter with saturating count.
// Options  : LOT_DEBOUNCE_EN - per-sensor debouncers in each lane decoder
// Revision : 1.0 - initial release
// ============================================================================
module lot_occupancy_counter
    import lot_occupancy_pkg::*;
#(
    parameter  int LANES     = 2,
    parameter  int CAPACITY  = 200,
    parameter  int DB_CYCLES = 20,
    localparam int CNT_W     = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LANES-1:0] a,
    input  logic [LANES-1:0] b,
    input  logic             clr,
    output logic [LANES-1:0] db_a,
    output logic [LANES-1:0] db_b,
    output logic [LANES-1:0] enter,
    output logic [LANES-1:0] exit,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             err_ovf,
    output logic             err_udf
);

    localparam int                        c_sum_w = CNT_W + 4;
    localparam logic signed [c_sum_w-1:0] c_cap_s = c_sum_w'(CAPACITY);
    localparam logic [CNT_W-1:0]          c_cap   = CNT_W'(CAPACITY);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        lot_lane_decoder #(
            .DB_CYCLES (DB_CYCLES)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .a     (a[l]),
            .b     (b[l]),
            .db_a  (db_a[l]),
            .db_b  (db_b[l]),
            .enter (enter[l]),
            .exit  (exit[l])
        );
    end

    logic [c_max_lanes-1:0]     w_enter8;
    logic [c_max_lanes-1:0]     w_exit8;
    logic [3:0]                 w_n_en;
    logic [3:0]                 w_n_ex;
    logic signed [c_sum_w-1:0]  w_sum;
    logic [CNT_W-1:0]           r_count;
    logic                       r_ovf;
    logic                       r_udf;

    always_comb begin
        w_enter8             = '0;
        w_exit8              = '0;
        w_enter8[LANES-1:0]  = enter;
        w_exit8[LANES-1:0]   = exit;
    end

    assign w_n_en = popcount8(w_enter8);
    assign w_n_ex = popcount8(w_exit8);

    // Wide enough that count + 8 and 0 - 8 never wrap.
    assign w_sum = {4'b0000, r_count} + {{CNT_W{1'b0}}, w_n_en} - {{CNT_W{1'b0}}, w_n_ex};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (w_sum[c_sum_w-1]) begin
            r_count <= '0;
            r_udf   <= 1'b1;
        end else if (w_sum > c_cap_s) begin
            r_count <= c_cap;
            r_ovf   <= 1'b1;
        end else begin
            r_count <= w_sum[CNT_W-1:0];
        end
    end

    assign count   = r_count;
    assign full    = (r_count == c_cap);
    assign empty   = (r_count == '0);
    assign err_ovf = r_ovf;
    assign err_udf = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_lot_occupancy_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lot_occupancy_counter
// Brief    : Directed bench with a behavioural occupancy model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lot_occupancy_counter;

    localparam int LANES     = 2;
    localparam int CAPACITY  = 2;
    localparam int DB_CYCLES = 4;
    localparam int CNT_W     = $clog2(CAPACITY + 1);
    localparam int HOLD      = DB_CYCLES + 5;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic             clr   = 1'b0;
    logic [LANES-1:0] a     = '0;
    logic [LANES-1:0] b     = '0;
    logic [LANES-1:0] db_a, db_b, enter, exit;
    logic [CNT_W-1:0] count;
    logic             full, empty, err_ovf, err_udf;

    lot_occupancy_counter #(
        .LANES     (LANES),
        .CAPACITY  (CAPACITY),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .clr     (clr),
        .db_a    (db_a),
        .db_b    (db_b),
        .enter   (enter),
        .exit    (exit),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .err_ovf (err_ovf),
        .err_udf (err_udf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [LANES-1:0]     m_s1a, m_s2a, m_s1b, m_s2b, m_dba, m_dbb;
    logic [DB_CYCLES-1:0] m_wa [LANES];
    logic [DB_CYCLES-1:0] m_wb [LANES];
    int                   m_st [LANES];   // 0 idle, +k entering step k, -k exiting step k
    logic [LANES-1:0]     m_enter, m_exit, m_en_n, m_ex_n;
    int                   m_count, m_nxt, m_np;
    logic                 m_ovf, m_udf;

    // Progress along lead-blocked, both-blocked, trail-blocked, clear. 4 = completed.
    function automatic int advance(input int p, input logic lead, input logic trail);
        case (p)
            1:       return (lead && trail) ? 2 : (lead && !trail) ? 1 : 0;
            2:       return (!lead && trail) ? 3 : (lead && !trail) ? 1 : (lead && trail) ? 2 : 0;
            3:       return (!lead && !trail) ? 4 : (lead && trail) ? 2 : (!lead && trail) ? 3 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_s1a = '0; m_s2a = '0; m_s1b = '0; m_s2b = '0; m_dba = '0; m_dbb = '0;
        m_enter = '0; m_exit = '0; m_count = 0; m_ovf = 1'b0; m_udf = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            m_wa[l] = '0; m_wb[l] = '0; m_st[l] = 0;
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            model_reset();
        end else begin
            if (clr) begin
                m_count = 0; m_ovf = 1'b0; m_udf = 1'b0;
            end else begin
                m_nxt = m_count + $countones(m_enter) - $countones(m_exit);
                if (m_nxt > CAPACITY) begin
                    m_count = CAPACITY; m_ovf = 1'b1;
                end else if (m_nxt < 0) begin
                    m_count = 0; m_udf = 1'b1;
                end else begin
                    m_count = m_nxt;
                end
            end
            m_en_n = '0;
            m_ex_n = '0;
            for (int l = 0; l < LANES; l++) begin
                if (m_st[l] == 0) begin
                    m_st[l] = (m_dba[l] && !m_dbb[l]) ? 1 : (!m_dba[l] && m_dbb[l]) ? -1 : 0;
                end else if (m_st[l] > 0) begin
                    m_np = advance(m_st[l], m_dba[l], m_dbb[l]);
                    if (m_np == 4) begin m_en_n[l] = 1'b1; m_np = 0; end
                    m_st[l] = m_np;
                end else begin
                    m_np = advance(-m_st[l], m_dbb[l], m_dba[l]);
                    if (m_np == 4) begin m_ex_n[l] = 1'b1; m_np = 0; end
                    m_st[l] = -m_np;
                end
            end
            m_enter = m_en_n;
            m_exit  = m_ex_n;
            for (int l = 0; l < LANES; l++) begin
`ifdef LOT_DEBOUNCE_EN
                m_wa[l] = {m_wa[l][DB_CYCLES-2:0], m_s2a[l]};
                m_wb[l] = {m_wb[l][DB_CYCLES-2:0], m_s2b[l]};
                if (m_wa[l] == {DB_CYCLES{~m_dba[l]}}) m_dba[l] = ~m_dba[l];
                if (m_wb[l] == {DB_CYCLES{~m_dbb[l]}}) m_dbb[l] = ~m_dbb[l];
`else
                m_dba[l] = m_s1a[l];
                m_dbb[l] = m_s1b[l];
`endif
            end
            m_s2a = m_s1a; m_s2b = m_s1b;
            m_s1a = a;     m_s1b = b;
        end
    end

    // ---------------- per-cycle compare ----------------
    int t_en = 0, t_ex = 0, seen_dba0 = 0;

    always @(posedge clk) begin
        #1;
        check("db_a",    db_a,    m_dba);
        check("db_b",    db_b,    m_dbb);
        check("enter",   enter,   m_enter);
        check("exit",    exit,    m_exit);
        check("count",   count,   m_count);
        check("full",    full,    (m_count == CAPACITY) ? 1 : 0);
        check("empty",   empty,   (m_count == 0) ? 1 : 0);
        check("err_ovf", err_ovf, m_ovf);
        check("err_udf", err_udf, m_udf);
        t_en += $countones(enter);
        t_ex += $countones(exit);
        if (db_a[0]) seen_dba0++;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [LANES-1:0] av, input logic [LANES-1:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        repeat (HOLD - 1) @(negedge clk);
    endtask

    task automatic seq4(input logic [LANES-1:0] a0, b0, a1, b1, a2, b2, a3, b3);
        drive(a0, b0);
        drive(a1, b1);
        drive(a2, b2);
        drive(a3, b3);
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    int e0, x0, s0;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full",  full,  0);
        check("rst_db",    {db_a, db_b}, 0);
        check("rst_flags", {err_ovf, err_udf}, 0);
        reset = 1'b0;

        // lane 0 entry
        e0 = t_en;
        seq4(2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
        check("entry0_pulses", t_en - e0, 1);
        check("entry0_count",  count, 1);
        check("entry0_empty",  empty, 0);
        check("entry0_model",  m_count, 1);

        // lane 1 exit
        x0 = t_ex;
        seq4(2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
        check("exit1_pulses", t_ex - x0, 1);
        check("exit1_count",  count, 0);
        check("exit1_empty",  empty, 1);

        // aborted entry on lane 0
        e0 = t_en; x0 = t_ex;
        seq4(2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        check("abort_pulses", (t_en - e0) + (t_ex - x0), 0);
        check("abort_count",  count, 0);

        // bouncing outer beam on lane 0
        e0 = t_en; x0 = t_ex; s0 = seen_dba0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i % (DB_CYCLES - 1) == 0) a[0] = ~a[0];
        end
        @(negedge clk) a = '0;
        repeat (HOLD) @(negedge clk);
`ifdef LOT_DEBOUNCE_EN
        check("bounce_db_a", seen_dba0 - s0, 0);
`else
        check("bounce_follow", (seen_dba0 - s0) > 0, 1);
`endif
        check("bounce_pulses", (t_en - e0) + (t_ex - x0), 0);

        // count 1, then both lanes enter together at capacity 2
        seq4(2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
        check("pre_dual_count", count, 1);
        seq4(2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00);
        check("dual_count", count, 2);
        check("dual_full",  full, 1);
        check("dual_ovf",   err_ovf, 1);
        check("dual_model", m_count, 2);
        pulse_clr();
        check("clr_count", count, 0);
        check("clr_ovf",   err_ovf, 0);
        check("clr_empty", empty, 1);

        // exit on lane 0 and entry on lane 1 complete together at count 0
        e0 = t_en; x0 = t_ex;
        seq4(2'b10, 2'b01, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00);
        check("mix_enter", t_en - e0, 1);
        check("mix_exit",  t_ex - x0, 1);
        check("mix_count", count, 0);
        check("mix_udf",   err_udf, 0);

        // exit at count 0 underflows
        seq4(2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        check("udf_count", count, 0);
        check("udf_flag",  err_udf, 1);
        pulse_clr();
        check("clr_udf", err_udf, 0);

        // reset in the middle of an entry
        seq4(2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
        check("pre_rst_count", count, 1);
        drive(2'b01, 2'b00);
        drive(2'b01, 2'b01);
        e0 = t_en; x0 = t_ex;
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drive(2'b00, 2'b01);
        drive(2'b00, 2'b00);
        repeat (4) @(negedge clk);
        check("midrst_pulses", (t_en - e0) + (t_ex - x0), 0);
        check("midrst_count",  count, 0);
        check("midrst_model",  m_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
